// File: rtl/shift_ctrl_pkg.sv
// shift_ctrl_pkg: state encoding and width limits shared by the shift sequencer.
package shift_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 16;
endpackage

// File: rtl/shift_reg_en.sv
// shift_reg_en: enable-gated serial-in/parallel-out register, shift direction set by LSB_FIRST.
module shift_reg_en #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (en)
            q <= LSB_FIRST ? {din, q[WIDTH-1:1]} : {q[WIDTH-2:0], din};
    end
endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: serializes a parallel word onto o_SD/o_SEN with stall support
// and rebuilds it in a loopback register for o_Q.
module shift_seq_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_VALID,
    input  logic [WIDTH-1:0] i_DATA,
    output logic             o_READY,
    input  logic             i_STALL,
    output logic             o_SD,
    output logic             o_SEN,
    output logic             o_BUSY,
    output logic             o_DONE,
    output logic [WIDTH-1:0] o_Q
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state, state_n;
    logic [CW-1:0] cnt, idx;
    logic [WIDTH-1:0] load;
    logic hs, last;

    assign o_READY = (state == IDLE) && !i_RST;
    assign hs      = i_VALID && o_READY;
    assign last    = cnt == LAST;
    assign o_SEN   = (state == SHIFT) && !i_STALL;
    assign o_BUSY  = state != IDLE;
    assign o_DONE  = state == DONE;

    always_comb begin
        idx     = LSB_FIRST ? cnt : LAST - cnt;
        o_SD    = (state == SHIFT) && load[idx];
        state_n = (state == IDLE)  ? (hs ? SHIFT : IDLE) :
                  (state == SHIFT) ? ((o_SEN && last) ? DONE : SHIFT) : IDLE;
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST)
            state <= IDLE;
        else
            state <= state_n;
    end

    // cnt parks at WIDTH-1 after the last bit so it never wraps inside a word
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            cnt  <= '0;
            load <= '0;
        end else if (hs) begin
            cnt  <= '0;
            load <= i_DATA;
        end else if (o_SEN && !last) begin
            cnt  <= cnt + 1'b1;
        end
    end

    shift_reg_en #(.WIDTH(WIDTH), .LSB_FIRST(LSB_FIRST)) u_loop (
        .clk (i_CLK),
        .rst (i_RST),
        .clr (hs),
        .en  (o_SEN),
        .din (o_SD),
        .q   (o_Q)
    );
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: three configurations (W4 MSB, W4 LSB, W8 MSB) on shared controls,
// compared each cycle against a word/bit-count reference model.
module tb_shift_seq_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, valid = 1'b0, stall = 1'b0;
    logic [3:0] d4 = '0;
    logic [7:0] d8 = '0;
    logic [2:0] ready, sd, sen, busy, done;
    logic [3:0] q0, q1;
    logic [7:0] q2;

    shift_seq_ctrl #(.WIDTH(4), .LSB_FIRST(1'b0)) dut0 (
        .i_CLK(clk), .i_RST(rst), .i_VALID(valid), .i_DATA(d4), .o_READY(ready[0]),
        .i_STALL(stall), .o_SD(sd[0]), .o_SEN(sen[0]), .o_BUSY(busy[0]), .o_DONE(done[0]), .o_Q(q0));
    shift_seq_ctrl #(.WIDTH(4), .LSB_FIRST(1'b1)) dut1 (
        .i_CLK(clk), .i_RST(rst), .i_VALID(valid), .i_DATA(d4), .o_READY(ready[1]),
        .i_STALL(stall), .o_SD(sd[1]), .o_SEN(sen[1]), .o_BUSY(busy[1]), .o_DONE(done[1]), .o_Q(q1));
    shift_seq_ctrl #(.WIDTH(8), .LSB_FIRST(1'b0)) dut2 (
        .i_CLK(clk), .i_RST(rst), .i_VALID(valid), .i_DATA(d8), .o_READY(ready[2]),
        .i_STALL(stall), .o_SD(sd[2]), .o_SEN(sen[2]), .o_BUSY(busy[2]), .o_DONE(done[2]), .o_Q(q2));

    int checks = 0, failures = 0, cyc = 0;
    int wid[3] = '{4, 4, 8};
    int lsb[3] = '{0, 1, 0};
    int ph[3], word[3], sent[3];
    int hs_cyc[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] q_of(input int k);
        return k == 0 ? {28'd0, q0} : k == 1 ? {28'd0, q1} : {24'd0, q2};
    endfunction

    task automatic step(input logic r, input logic v, input logic s,
                        input logic [3:0] a, input logic [7:0] b);
        @(negedge clk);
        rst = r; valid = v; stall = s; d4 = a; d8 = b;
        #1;
        for (int k = 0; k < 3; k++) begin
            int bit_pos;
            logic e_sd;
            bit_pos = lsb[k] != 0 ? sent[k] : wid[k] - 1 - sent[k];
            e_sd = !r && ph[k] == 1 && ((word[k] >> bit_pos) & 1) == 1;
            check($sformatf("ready%0d", k), 32'(ready[k]), 32'(!r && ph[k] == 0));
            check($sformatf("busy%0d", k),  32'(busy[k]),  32'(!r && ph[k] != 0));
            check($sformatf("done%0d", k),  32'(done[k]),  32'(!r && ph[k] == 2));
            check($sformatf("sen%0d", k),   32'(sen[k]),   32'(!r && ph[k] == 1 && !s));
            check($sformatf("sd%0d", k),    32'(sd[k]),    32'(e_sd));
            if (r)
                check($sformatf("q_rst%0d", k), q_of(k), 0);
            else if (ph[k] == 2)
                check($sformatf("q_done%0d", k), q_of(k), 32'(word[k]));
        end
        if (v && ready[0]) hs_cyc.push_back(cyc);
        @(posedge clk);
        cyc++;
        for (int k = 0; k < 3; k++) begin
            if (r) begin
                ph[k] = 0;
                sent[k] = 0;
            end else if (ph[k] == 0) begin
                if (v) begin
                    word[k] = k == 2 ? int'(b) : int'(a);
                    sent[k] = 0;
                    ph[k] = 1;
                end
            end else if (ph[k] == 1) begin
                if (!s) begin
                    sent[k]++;
                    if (sent[k] == wid[k]) ph[k] = 2;
                end
            end else begin
                ph[k] = 0;
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin ph[k] = 0; word[k] = 0; sent[k] = 0; end
        repeat (2) step(1, 0, 0, 4'h0, 8'h00);
        step(0, 0, 0, 4'h0, 8'h00);
        // MSB word 1011 (W4) and 0x96 (W8)
        step(0, 1, 0, 4'b1011, 8'h96);
        repeat (10) step(0, 0, 0, 4'h0, 8'h00);
        // 1100, stalled for three cycles after the second bit
        step(0, 1, 0, 4'b1100, 8'h3C);
        repeat (2) step(0, 0, 0, 4'hF, 8'hFF);
        repeat (3) step(0, 0, 1, 4'hF, 8'hFF);
        repeat (10) step(0, 0, 0, 4'h0, 8'h00);
        // reset during the third bit
        step(0, 1, 0, 4'h6, 8'hA5);
        repeat (2) step(0, 0, 0, 4'h0, 8'h00);
        step(1, 0, 0, 4'h0, 8'h00);
        repeat (3) step(0, 0, 0, 4'h0, 8'h00);
        // back-to-back with valid held high and data churning while busy
        hs_cyc.delete();
        for (int i = 0; i < 14; i++)
            step(0, 1, 0, i == 0 ? 4'hA : i == 6 ? 4'h5 : 4'($urandom), 8'($urandom));
        check("hs_count", 32'(hs_cyc.size() >= 2), 1);
        if (hs_cyc.size() >= 2) check("hs_spacing", 32'(hs_cyc[1] - hs_cyc[0]), 6);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                 4'($urandom), 8'($urandom));
        repeat (12) step(0, 0, 0, 4'h0, 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: serial word length in bits, legal range 2..16.
REQ-002 Parameter LSB_FIRST, default 0: 0 = MSB shifted first, 1 = LSB shifted first.
REQ-003 i_CLK  input  1  single clock, all state updates on rising edge.
REQ-004 i_RST  input  1  reset, asynchronous, active-high.
REQ-005 i_VALID  input  1  parallel word offered on i_DATA.
REQ-006 i_DATA  input  WIDTH  parallel word to serialize.
REQ-007 o_READY  output  1  controller accepts a word this cycle.
REQ-008 i_STALL  input  1  pause shifting while high.
REQ-009 o_SD  output  1  serial data bit to the downstream shift register.
REQ-010 o_SEN  output  1  shift enable; high in every cycle where o_SD is a valid bit.
REQ-011 o_BUSY  output  1  high from word acceptance through the DONE cycle.
REQ-012 o_DONE  output  1  one-cycle pulse: word fully shifted.
REQ-013 o_Q  output  WIDTH  loopback word rebuilt from o_SD/o_SEN; valid while o_DONE is high.

Function
REQ-014 States SHALL be IDLE, SHIFT and DONE; no other reachable state.
REQ-015 o_READY SHALL be 1 only in IDLE with i_RST low; handshake completes on an edge where i_VALID && o_READY.
REQ-016 On handshake, i_DATA SHALL be captured into an internal load register, the bit counter set to 0, and the state set to SHIFT.
REQ-017 In SHIFT with i_STALL low, o_SEN SHALL be 1, o_SD SHALL be load-register bit (WIDTH-1-cnt) for LSB_FIRST=0 or bit cnt for LSB_FIRST=1, and cnt SHALL increment.
REQ-018 In SHIFT with i_STALL high, o_SEN SHALL be 0, and cnt, o_SD and the load register SHALL hold.
REQ-019 After the enabled cycle with cnt == WIDTH-1, the state SHALL move to DONE, so an unstalled word takes exactly WIDTH SHIFT cycles.
REQ-020 DONE SHALL last one cycle with o_DONE=1 and o_SEN=0, then return to IDLE.
REQ-021 The minimum handshake-to-handshake spacing SHALL be WIDTH+2 cycles.
REQ-022 The loopback register SHALL shift only when o_SEN=1:
- LSB_FIRST=0: shift left, inserting o_SD at bit 0.
- LSB_FIRST=1: shift right, inserting o_SD at bit WIDTH-1.
REQ-023 In the DONE cycle, o_Q SHALL equal the captured word.
REQ-024 The loopback register SHALL be cleared on each handshake.
REQ-025 i_VALID SHALL be ignored outside IDLE, and i_DATA changes after capture SHALL have no effect.
REQ-026 i_STALL SHALL be ignored in IDLE and DONE.
REQ-027 o_BUSY SHALL equal (state != IDLE).
REQ-028 The counter SHALL be wide enough for WIDTH-1 and SHALL never wrap within a word.

Reset
REQ-029 When i_RST is high, the following SHALL hold immediately (asynchronously), independent of the clock:
- state = IDLE, cnt = 0;
- load register = 0, loopback register = 0;
- o_SD = 0, o_SEN = 0, o_DONE = 0, o_BUSY = 0, o_Q = 0, o_READY = 0.
REQ-030 A reset asserted mid-SHIFT SHALL abort the word with no o_DONE pulse.
REQ-031 o_READY SHALL rise in the first cycle after i_RST deasserts.

Structure
REQ-032 State encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) SHALL live in shared package shift_ctrl_pkg, alongside the WIDTH range-limit constants.
REQ-033 The loopback register SHALL be a separate sub-module, shift_reg_en: a WIDTH-bit enable-gated serial-in/parallel-out register with a direction parameter and asynchronous active-high reset.

Verification
REQ-034 Basic MSB-first shift: WIDTH=4, LSB_FIRST=0, handshake i_DATA=4'b1011 -> o_SD = 1,0,1,1 on 4 consecutive o_SEN cycles; o_DONE on the next cycle with o_Q=4'b1011.
REQ-035 LSB-first shift: LSB_FIRST=1, i_DATA=4'b1100 -> o_SD = 0,0,1,1; o_Q=4'b1100 at o_DONE.
REQ-036 Stall mid-word: i_STALL high for 3 cycles after the 2nd bit -> o_SEN=0 and o_SD held for those 3 cycles; o_DONE arrives 3 cycles later; o_Q unchanged.
REQ-037 Reset mid-word: i_RST pulsed during the 3rd bit -> all outputs 0 immediately; no o_DONE; o_READY=1 on the cycle after release.
REQ-038 Back-to-back words: i_VALID held high with 4'hA then 4'h5 -> second handshake exactly WIDTH+2 cycles after the first; i_DATA changes while busy are ignored.
REQ-039 Width sweep: WIDTH=8, i_DATA=8'h96 -> 8 o_SEN cycles; o_Q=8'h96 at o_DONE.
